// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants and the receive parser state type.
// Used by the receive parser and by the transmit path, so that both
// sides agree on the framing bytes and the header lengths.
package eth_pkg;

  // Framing and protocol identifiers
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;   // IPv4 with no options
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Header lengths in bytes
  localparam logic [15:0] ETH_HDR_LEN = 16'd14;
  localparam logic [15:0] IP_HDR_LEN  = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  typedef enum logic [2:0] {
    WAIT_END,
    IDLE,
    PREAMBLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    DISCARD
  } rx_state_t;

endpackage

// File: rtl/udp_rx_parser.sv
// GMII receive-side UDP parser.
// Strips preamble/SFD, Ethernet II, IPv4 and UDP headers, filters on local
// MAC (or broadcast), local IP and local port, and streams out the UDP
// payload with start/end markers. Frames that fail a header check raise a
// one-cycle pkt_drop; payloads cut short raise a one-cycle udp_abort.
//
// Ports:
//   gmii_rx_clk   125 MHz receive clock (only clock)
//   rst           synchronous active-high reset
//   gmii_rx_dv/er/rxd  GMII receive byte stream
//   udp_data/valid/sop/eop  payload stream, one cycle behind the input
//   udp_len, udp_src_port, src_ip  header fields of the last accepted packet
//   udp_abort     payload truncated or errored
//   pkt_drop      frame rejected before any payload
//   pkt_cnt       completed good packets (wraps)
module udp_rx_parser
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] LOCAL_IP    = 32'hC0A8_000B,
  parameter logic [15:0] LOCAL_PORT  = 16'd8080,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  udp_data,
  output logic        udp_valid,
  output logic        udp_sop,
  output logic        udp_eop,
  output logic [15:0] udp_len,
  output logic [15:0] udp_src_port,
  output logic [31:0] src_ip,
  output logic        udp_abort,
  output logic        pkt_drop,
  output logic [15:0] pkt_cnt
);

  rx_state_t   state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  // Last five received bytes; together with the current byte this gives
  // a six-byte window wide enough for the MAC compare.
  logic [39:0] hdr_sr_reg, hdr_sr_next;
  logic        mac_ok_reg, mac_ok_next;
  logic [31:0] src_ip_cap_reg, src_ip_cap_next;
  logic [15:0] src_port_cap_reg, src_port_cap_next;
  logic [15:0] len_cap_reg, len_cap_next;

  logic [7:0]  udp_data_reg, udp_data_next;
  logic        udp_valid_reg, udp_valid_next;
  logic        udp_sop_reg, udp_sop_next;
  logic        udp_eop_reg, udp_eop_next;
  logic [15:0] udp_len_reg, udp_len_next;
  logic [15:0] udp_src_port_reg, udp_src_port_next;
  logic [31:0] src_ip_reg, src_ip_next;
  logic        udp_abort_reg, udp_abort_next;
  logic        pkt_drop_reg, pkt_drop_next;
  logic [15:0] pkt_cnt_reg, pkt_cnt_next;

  logic        rx_ok;
  logic [15:0] word16;
  logic [31:0] word32;
  logic [47:0] word48;
  logic        mac_match, len_ok;
  logic        last_byte, hdr_fail;

  assign rx_ok  = gmii_rx_dv && !gmii_rx_er;
  assign word16 = {hdr_sr_reg[7:0], gmii_rxd};
  assign word32 = {hdr_sr_reg[23:0], gmii_rxd};
  assign word48 = {hdr_sr_reg, gmii_rxd};

  assign mac_match = (word48 == LOCAL_MAC) || (word48 == BROADCAST_MAC);
  // A zero-length payload is refused as well as an oversize one.
  assign len_ok = (word16 > UDP_HDR_LEN) && ((word16 - UDP_HDR_LEN) <= MAX_PAYLOAD);

  // Per-state field checks on the byte currently on gmii_rxd
  always_comb begin
    last_byte = 1'b0;
    hdr_fail  = 1'b0;
    case (state_reg)
      ETH_HDR: begin
        last_byte = (cnt_reg == ETH_HDR_LEN - 16'd1);
        hdr_fail  = last_byte && (!mac_ok_reg || (word16 != ETH_TYPE_IPV4));
      end
      IP_HDR: begin
        last_byte = (cnt_reg == IP_HDR_LEN - 16'd1);
        hdr_fail  = ((cnt_reg == 16'd0) && (gmii_rxd != IP_VER_IHL)) ||
                    ((cnt_reg == 16'd9) && (gmii_rxd != IP_PROTO_UDP)) ||
                    (last_byte && (word32 != LOCAL_IP));
      end
      UDP_HDR: begin
        last_byte = (cnt_reg == UDP_HDR_LEN - 16'd1);
        hdr_fail  = ((cnt_reg == 16'd3) && (word16 != LOCAL_PORT)) ||
                    ((cnt_reg == 16'd5) && !len_ok);
      end
      PAYLOAD: last_byte = (cnt_reg + 16'd1 == udp_len_reg);
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_reg <= WAIT_END;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_END, DISCARD: if (!gmii_rx_dv) state_next = IDLE;
      IDLE: if (gmii_rx_dv) state_next = (gmii_rxd == PREAMBLE_BYTE) ? PREAMBLE : DISCARD;
      PREAMBLE: begin
        if (!rx_ok)                         state_next = DISCARD;
        else if (gmii_rxd == SFD_BYTE)      state_next = ETH_HDR;
        else if (gmii_rxd != PREAMBLE_BYTE) state_next = DISCARD;
      end
      ETH_HDR: begin
        if (!rx_ok || hdr_fail) state_next = DISCARD;
        else if (last_byte)     state_next = IP_HDR;
      end
      IP_HDR: begin
        if (!rx_ok || hdr_fail) state_next = DISCARD;
        else if (last_byte)     state_next = UDP_HDR;
      end
      UDP_HDR: begin
        if (!rx_ok || hdr_fail) state_next = DISCARD;
        else if (last_byte)     state_next = PAYLOAD;
      end
      PAYLOAD: if (!rx_ok || last_byte) state_next = WAIT_END;
      default: state_next = WAIT_END;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    cnt_next          = cnt_reg;
    hdr_sr_next       = hdr_sr_reg;
    mac_ok_next       = mac_ok_reg;
    src_ip_cap_next   = src_ip_cap_reg;
    src_port_cap_next = src_port_cap_reg;
    len_cap_next      = len_cap_reg;
    udp_data_next     = udp_data_reg;
    udp_valid_next    = 1'b0;
    udp_sop_next      = 1'b0;
    udp_eop_next      = 1'b0;
    udp_len_next      = udp_len_reg;
    udp_src_port_next = udp_src_port_reg;
    src_ip_next       = src_ip_reg;
    udp_abort_next    = 1'b0;
    pkt_drop_next     = 1'b0;
    pkt_cnt_next      = pkt_cnt_reg;

    // The byte counter restarts at every state change so each header
    // and the payload count from zero.
    if (state_next != state_reg) cnt_next = 16'd0;
    else if (gmii_rx_dv)         cnt_next = cnt_reg + 16'd1;

    if (gmii_rx_dv) hdr_sr_next = {hdr_sr_reg[31:0], gmii_rxd};

    // Any exit from a header state into DISCARD is a rejected frame.
    if ((state_reg inside {PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR}) && (state_next == DISCARD))
      pkt_drop_next = 1'b1;

    case (state_reg)
      ETH_HDR: if (cnt_reg == 16'd5) mac_ok_next = mac_match;
      IP_HDR:  if (cnt_reg == 16'd15) src_ip_cap_next = word32;
      UDP_HDR: begin
        if (cnt_reg == 16'd1) src_port_cap_next = word16;
        if (cnt_reg == 16'd5) len_cap_next = word16 - UDP_HDR_LEN;
        if (state_next == PAYLOAD) begin
          udp_len_next      = len_cap_reg;
          udp_src_port_next = src_port_cap_reg;
          src_ip_next       = src_ip_cap_reg;
        end
      end
      PAYLOAD: begin
        if (!rx_ok) begin
          udp_abort_next = 1'b1;
        end else begin
          udp_data_next  = gmii_rxd;
          udp_valid_next = 1'b1;
          udp_sop_next   = (cnt_reg == 16'd0);
          udp_eop_next   = last_byte;
          if (last_byte) pkt_cnt_next = pkt_cnt_reg + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      cnt_reg          <= '0;
      hdr_sr_reg       <= '0;
      mac_ok_reg       <= 1'b0;
      src_ip_cap_reg   <= '0;
      src_port_cap_reg <= '0;
      len_cap_reg      <= '0;
      udp_data_reg     <= '0;
      udp_valid_reg    <= 1'b0;
      udp_sop_reg      <= 1'b0;
      udp_eop_reg      <= 1'b0;
      udp_len_reg      <= '0;
      udp_src_port_reg <= '0;
      src_ip_reg       <= '0;
      udp_abort_reg    <= 1'b0;
      pkt_drop_reg     <= 1'b0;
      pkt_cnt_reg      <= '0;
    end else begin
      cnt_reg          <= cnt_next;
      hdr_sr_reg       <= hdr_sr_next;
      mac_ok_reg       <= mac_ok_next;
      src_ip_cap_reg   <= src_ip_cap_next;
      src_port_cap_reg <= src_port_cap_next;
      len_cap_reg      <= len_cap_next;
      udp_data_reg     <= udp_data_next;
      udp_valid_reg    <= udp_valid_next;
      udp_sop_reg      <= udp_sop_next;
      udp_eop_reg      <= udp_eop_next;
      udp_len_reg      <= udp_len_next;
      udp_src_port_reg <= udp_src_port_next;
      src_ip_reg       <= src_ip_next;
      udp_abort_reg    <= udp_abort_next;
      pkt_drop_reg     <= pkt_drop_next;
      pkt_cnt_reg      <= pkt_cnt_next;
    end
  end

  assign udp_data     = udp_data_reg;
  assign udp_valid    = udp_valid_reg;
  assign udp_sop      = udp_sop_reg;
  assign udp_eop      = udp_eop_reg;
  assign udp_len      = udp_len_reg;
  assign udp_src_port = udp_src_port_reg;
  assign src_ip       = src_ip_reg;
  assign udp_abort    = udp_abort_reg;
  assign pkt_drop     = pkt_drop_reg;
  assign pkt_cnt      = pkt_cnt_reg;

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed bench for udp_rx_parser: a table of frames with hand-computed
// expected outputs, plus hand-written sequences for reset mid-payload and
// back-to-back frames with a single-cycle gap.
module tb_udp_rx_parser;

  localparam logic [47:0] LMAC  = 48'h000A_3501_FEC0;
  localparam logic [47:0] BMAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] LIP   = 32'hC0A8_000B;
  localparam logic [15:0] LPORT = 16'd8080;
  localparam int          PAY0  = 50;  // index of first payload byte in a frame

  logic        clk = 1'b0;
  logic        rst, dv, er;
  logic [7:0]  rxd;
  logic [7:0]  udp_data;
  logic        udp_valid, udp_sop, udp_eop, udp_abort, pkt_drop;
  logic [15:0] udp_len, udp_src_port, pkt_cnt;
  logic [31:0] src_ip;

  always #4 clk = ~clk;

  udp_rx_parser dut (
    .gmii_rx_clk (clk),
    .rst         (rst),
    .gmii_rx_dv  (dv),
    .gmii_rx_er  (er),
    .gmii_rxd    (rxd),
    .udp_data    (udp_data),
    .udp_valid   (udp_valid),
    .udp_sop     (udp_sop),
    .udp_eop     (udp_eop),
    .udp_len     (udp_len),
    .udp_src_port(udp_src_port),
    .src_ip      (src_ip),
    .udp_abort   (udp_abort),
    .pkt_drop    (pkt_drop),
    .pkt_cnt     (pkt_cnt)
  );

  typedef struct {
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [15:0] dport;
    logic [31:0] sip;
    logic [15:0] sport;
    int          n;        // payload bytes in the frame
    int          trunc;    // dv drops after this many payload bytes (-1: none)
    int          er_at;    // payload byte index carrying er=1 (-1: none)
    int          e_valid;
    int          e_eop;
    int          e_abort;
    int          e_drop;
    int          e_cnt;
    int          e_len;
    logic [31:0] e_sip;
    logic [15:0] e_sport;
  } vec_t;

  vec_t vecs[9];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Output monitor, sampled on the falling edge
  logic [7:0] got_d[$];
  bit         got_sop[$];
  bit         got_eop[$];
  int         abort_n = 0;
  int         drop_n  = 0;

  always @(negedge clk) begin
    if (udp_valid === 1'b1) begin
      got_d.push_back(udp_data);
      got_sop.push_back(udp_sop);
      got_eop.push_back(udp_eop);
    end
    if (udp_abort === 1'b1) abort_n++;
    if (pkt_drop === 1'b1) drop_n++;
  end

  logic [7:0] frm[$];

  task automatic build(input logic [47:0] dmac, input logic [31:0] dip, input logic [15:0] dport,
                       input logic [31:0] sip, input logic [15:0] sport, input int n,
                       input logic [7:0] base);
    logic [47:0] smac;
    logic [15:0] tl;
    logic [15:0] ul;
    smac = 48'h0011_2233_4455;
    tl   = 16'(28 + n);
    ul   = 16'(8 + n);
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) frm.push_back(dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) frm.push_back(smac[i*8 +: 8]);
    frm.push_back(8'h08); frm.push_back(8'h00);
    frm.push_back(8'h45); frm.push_back(8'h00); frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11); frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frm.push_back(sip[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) frm.push_back(dip[i*8 +: 8]);
    frm.push_back(sport[15:8]); frm.push_back(sport[7:0]);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ul[15:8]);    frm.push_back(ul[7:0]);
    frm.push_back(8'h00);       frm.push_back(8'h00);
    for (int i = 0; i < n; i++) frm.push_back(8'(base + i));
    while (frm.size() < 8 + 60) frm.push_back(8'h00);  // Ethernet minimum padding
    frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
  endtask

  // Inputs change 1 time unit after the rising edge and hold for one cycle.
  task automatic drive(input logic d_v, input logic d_e, input logic [7:0] d);
    dv  = d_v;
    er  = d_e;
    rxd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int stop, input int er_idx, input int gap);
    for (int i = 0; i < stop; i++) drive(1'b1, (i == er_idx), frm[i]);
    repeat (gap) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_frame(input string tag, input int g0, input int g1, input int a0, input int d0,
                             input int e_valid, input int e_eop, input int e_abort, input int e_drop,
                             input logic [7:0] base);
    int nv, mism, sop_n, sop_pos, eop_n, eop_pos;
    nv = g1 - g0;
    mism = 0; sop_n = 0; sop_pos = -1; eop_n = 0; eop_pos = -1;
    for (int i = 0; i < nv; i++) begin
      if (got_d[g0+i] !== 8'(base + i)) mism++;
      if (got_sop[g0+i]) begin
        if (sop_pos < 0) sop_pos = i;
        sop_n++;
      end
      if (got_eop[g0+i]) begin
        eop_pos = i;
        eop_n++;
      end
    end
    check({tag, " valid_bytes"}, nv, e_valid);
    check({tag, " payload_mismatches"}, mism, 0);
    check({tag, " sop_count"}, sop_n, (e_valid > 0) ? 1 : 0);
    check({tag, " sop_pos"}, sop_pos, (e_valid > 0) ? 0 : -1);
    check({tag, " eop_count"}, eop_n, e_eop);
    check({tag, " eop_pos"}, eop_pos, (e_eop != 0) ? e_valid - 1 : -1);
    check({tag, " abort_pulses"}, abort_n - a0, e_abort);
    check({tag, " drop_pulses"}, drop_n - d0, e_drop);
    $display("frame %s: bytes=%0d sop=%0d eop=%0d abort=%0d drop=%0d pkt_cnt=%0d",
             tag, nv, sop_n, eop_n, abort_n - a0, drop_n - d0, pkt_cnt);
  endtask

  initial begin
    int g0, a0, d0, stop, er_idx;

    //         dmac     dip            dport   sip            sport    n   trunc er  val eop ab dr cnt len  e_sip          e_sport
    vecs[0] = '{LMAC, LIP,           LPORT,  32'hC0A80002, 16'd5000, 4,   -1, -1,  4,  1, 0, 0, 1,  4, 32'hC0A80002, 16'd5000};
    vecs[1] = '{LMAC, LIP,           16'd8081, 32'hC0A80002, 16'd5000, 4, -1, -1,  0,  0, 0, 1, 1,  4, 32'hC0A80002, 16'd5000};
    vecs[2] = '{LMAC, LIP,           LPORT,  32'hC0A80003, 16'd6000, 1,   -1, -1,  1,  1, 0, 0, 2,  1, 32'hC0A80003, 16'd6000};
    vecs[3] = '{LMAC, LIP,           LPORT,  32'hC0A80004, 16'd7000, 100, 50, -1, 50,  0, 1, 0, 2, 100, 32'hC0A80004, 16'd7000};
    vecs[4] = '{48'h000A_3501_FEC1, LIP, LPORT, 32'hC0A800AA, 16'd1, 4, -1, -1,  0,  0, 0, 1, 2, 100, 32'hC0A80004, 16'd7000};
    vecs[5] = '{BMAC, LIP,           LPORT,  32'hC0A80005, 16'd1234, 3,   -1, -1,  3,  1, 0, 0, 3,  3, 32'hC0A80005, 16'd1234};
    vecs[6] = '{LMAC, 32'hC0A8000C,  LPORT,  32'hC0A800AB, 16'd2,    4,   -1, -1,  0,  0, 0, 1, 3,  3, 32'hC0A80005, 16'd1234};
    vecs[7] = '{LMAC, LIP,           LPORT,  32'hC0A800AC, 16'd3,    0,   -1, -1,  0,  0, 0, 1, 3,  3, 32'hC0A80005, 16'd1234};
    vecs[8] = '{LMAC, LIP,           LPORT,  32'hC0A80007, 16'd4000, 20,  -1, 10, 10,  0, 1, 0, 3, 20, 32'hC0A80007, 16'd4000};

    rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset pulses", {27'd0, udp_valid, udp_sop, udp_eop, udp_abort, pkt_drop}, 32'd0);
    check("reset pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    check("reset udp_len", {16'd0, udp_len}, 32'd0);
    check("reset src_port", {16'd0, udp_src_port}, 32'd0);
    check("reset src_ip", src_ip, 32'd0);
    check("reset udp_data", {24'd0, udp_data}, 32'd0);
    rst = 1'b0;
    repeat (2) drive(1'b0, 1'b0, 8'h00);

    for (int v = 0; v < 9; v++) begin
      g0 = got_d.size(); a0 = abort_n; d0 = drop_n;
      build(vecs[v].dmac, vecs[v].dip, vecs[v].dport, vecs[v].sip, vecs[v].sport, vecs[v].n, 8'h01);
      stop   = (vecs[v].trunc >= 0) ? PAY0 + vecs[v].trunc : frm.size();
      er_idx = (vecs[v].er_at >= 0) ? PAY0 + vecs[v].er_at : -1;
      send(stop, er_idx, 12);
      check_frame($sformatf("vec%0d", v), g0, got_d.size(), a0, d0, vecs[v].e_valid,
                  vecs[v].e_eop, vecs[v].e_abort, vecs[v].e_drop, 8'h01);
      check($sformatf("vec%0d pkt_cnt", v), {16'd0, pkt_cnt}, vecs[v].e_cnt);
      check($sformatf("vec%0d udp_len", v), {16'd0, udp_len}, vecs[v].e_len);
      check($sformatf("vec%0d src_ip", v), src_ip, vecs[v].e_sip);
      check($sformatf("vec%0d src_port", v), {16'd0, udp_src_port}, {16'd0, vecs[v].e_sport});
    end

    // Reset asserted while payload byte 20 is on the wire; dv stays high.
    build(LMAC, LIP, LPORT, 32'hC0A80008, 16'd5002, 40, 8'h01);
    for (int i = 0; i < PAY0 + 19; i++) drive(1'b1, 1'b0, frm[i]);
    rst = 1'b1;
    drive(1'b1, 1'b0, frm[PAY0 + 19]);
    rst = 1'b0;
    check("midrst pulses", {27'd0, udp_valid, udp_sop, udp_eop, udp_abort, pkt_drop}, 32'd0);
    check("midrst pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    check("midrst udp_len", {16'd0, udp_len}, 32'd0);
    check("midrst src_ip", src_ip, 32'd0);
    g0 = got_d.size(); a0 = abort_n; d0 = drop_n;
    for (int i = PAY0 + 20; i < frm.size(); i++) drive(1'b1, 1'b0, frm[i]);
    repeat (12) drive(1'b0, 1'b0, 8'h00);
    check_frame("midrst_tail", g0, got_d.size(), a0, d0, 0, 0, 0, 0, 8'h01);

    g0 = got_d.size(); a0 = abort_n; d0 = drop_n;
    build(LMAC, LIP, LPORT, 32'hC0A80006, 16'd5001, 4, 8'h10);
    send(frm.size(), -1, 12);
    check_frame("after_rst", g0, got_d.size(), a0, d0, 4, 1, 0, 0, 8'h10);
    check("after_rst pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
    check("after_rst src_ip", src_ip, 32'hC0A80006);
    check("after_rst src_port", {16'd0, udp_src_port}, 32'd5001);

    // Two good frames separated by a single dv=0 cycle.
    g0 = got_d.size(); a0 = abort_n; d0 = drop_n;
    build(LMAC, LIP, LPORT, 32'hC0A80009, 16'd5003, 4, 8'h20);
    send(frm.size(), -1, 1);
    build(LMAC, LIP, LPORT, 32'hC0A8000A, 16'd5004, 5, 8'h30);
    send(frm.size(), -1, 12);
    check_frame("b2b_first", g0, g0 + 4, a0, d0, 4, 1, 0, 0, 8'h20);
    check_frame("b2b_second", g0 + 4, got_d.size(), a0, d0, 5, 1, 0, 0, 8'h30);
    check("b2b pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
    check("b2b udp_len", {16'd0, udp_len}, 32'd5);
    check("b2b src_ip", src_ip, 32'hC0A8000A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
